// File: rtl/coax_buffered_rx.sv
// Buffered 3270 coax receiver: synchronises and oversamples the biphase line,
// finds the start sequence, decodes 10-bit words plus parity and queues them
// as {parity_error, data} in a first-word-fall-through FIFO.
//
// Handshake: the FIFO head (data, data_parity_error) is valid whenever empty
// is low; a read_strobe sampled high on a clock edge while !empty pops that
// word, and a read_strobe while empty is ignored.
module coax_buffered_rx #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DEPTH          = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       parity,
  output logic       active,
  output logic [9:0] data,
  output logic       data_parity_error,
  output logic       empty,
  output logic       full,
  input  logic       read_strobe,
  output logic       frame_end,
  output logic [2:0] error,
  output logic [2:0] dbg_state
);

  localparam int CPB     = CLOCKS_PER_BIT;
  localparam int CNT_MAX = 3 * CPB;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int AW      = $clog2(DEPTH);

  // Cell-timing thresholds, measured from the last accepted mid-bit edge.
  localparam logic [CW-1:0] C_Q3  = CW'(3 * CPB / 4);
  localparam logic [CW-1:0] C_Q5  = CW'(5 * CPB / 4);
  localparam logic [CW-1:0] C_TO  = CW'(5 * CPB / 4 + 1);
  localparam logic [CW-1:0] C_Q7  = CW'(7 * CPB / 4);
  localparam logic [CW-1:0] C_Q9  = CW'(9 * CPB / 4);
  localparam logic [CW-1:0] C_VTO = CW'(9 * CPB / 4 + 1);
  localparam logic [CW-1:0] C_T2  = CW'(2 * CPB);
  localparam logic [CW-1:0] C_MAX = CW'(CNT_MAX);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_VIOL, S_DATA, S_SYNC, S_END} state_t;

  state_t          state_q, state_d;
  logic            rx_s1_q, rx_s2_q, rx_d_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      ones_q, ones_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      sr_q, sr_d;
  logic            fell_q, fell_d;
  logic            push_q, push_d;
  logic [10:0]     push_word_q, push_word_d;
  logic            active_q, active_d;
  logic            frame_end_q, frame_end_d;
  logic [2:0]      error_q, error_d;

  logic [10:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;

  logic edge_det, rise, fall, in_win, timeout, perr;
  logic do_push, do_pop, overflow;

  assign edge_det = rx_s2_q ^ rx_d_q;
  assign rise     = edge_det & rx_s2_q;
  assign fall     = edge_det & ~rx_s2_q;
  assign in_win   = edge_det && (cnt_q >= C_Q3) && (cnt_q <= C_Q5);
  assign timeout  = (cnt_q == C_TO);
  assign perr     = (^{sr_q, rx_s2_q}) != parity;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign do_pop   = read_strobe && !empty;
  assign do_push  = push_q && (!full || do_pop);
  assign overflow = push_q && full && !do_pop;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q <= 1'b0;
      rx_s2_q <= 1'b0;
      rx_d_q  <= 1'b0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_d_q  <= rx_s2_q;
    end
  end

  // FSM state and decoder datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= C_MAX;
      ones_q      <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      fell_q      <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      active_q    <= 1'b0;
      frame_end_q <= 1'b0;
      error_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      fell_q      <= fell_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      active_q    <= active_d;
      frame_end_q <= frame_end_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic of the frame FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ones_q != 3'd0 && timeout && ones_q == 3'd5) state_d = S_VIOL;
      S_VIOL: begin
        if (rise) state_d = (fell_q && cnt_q >= C_Q7 && cnt_q <= C_Q9) ? S_DATA : S_IDLE;
        else if (cnt_q == C_VTO) state_d = S_IDLE;
      end
      S_DATA: begin
        if (timeout) state_d = S_IDLE;
        else if (in_win && bit_cnt_q == 4'd10) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (timeout) state_d = S_IDLE;
        else if (in_win) state_d = rx_s2_q ? S_DATA : S_END;
      end
      S_END: if (!edge_det && cnt_q == C_T2) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs: bit timing, shifting, flags and pushes.
  always_comb begin
    cnt_d       = (cnt_q == C_MAX) ? cnt_q : cnt_q + 1'b1;
    ones_d      = ones_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    fell_d      = fell_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    active_d    = active_q;
    frame_end_d = 1'b0;
    error_d     = error_q | {overflow, 2'b00};
    case (state_q)
      S_IDLE: begin
        if (ones_q == 3'd0) begin
          // Unanchored: the first rising edge is taken as the mid-bit of a 1.
          if (rise) begin
            cnt_d  = CW'(1);
            ones_d = 3'd1;
          end
        end else if (timeout) begin
          ones_d = 3'd0;
          fell_d = 1'b0;
        end else if (in_win) begin
          cnt_d  = CW'(1);
          ones_d = !rx_s2_q ? 3'd0 : (ones_q == 3'd5) ? 3'd5 : ones_q + 3'd1;
        end
      end
      S_VIOL: begin
        if (fall) fell_d = 1'b1;
        if (rise && fell_q && cnt_q >= C_Q7 && cnt_q <= C_Q9) begin
          cnt_d     = CW'(1);
          bit_cnt_d = '0;
          error_d   = {overflow, 2'b00};
          active_d  = 1'b1;
        end
      end
      S_DATA: begin
        if (timeout) begin
          error_d[1] = 1'b1;
          active_d   = 1'b0;
        end else if (in_win) begin
          cnt_d = CW'(1);
          if (bit_cnt_q == 4'd10) begin
            push_d      = 1'b1;
            push_word_d = {perr, sr_q};
            error_d[0]  = error_d[0] | perr;
            bit_cnt_d   = '0;
          end else begin
            sr_d      = {sr_q[8:0], rx_s2_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_SYNC: begin
        if (timeout) begin
          error_d[1] = 1'b1;
          active_d   = 1'b0;
        end else if (in_win) begin
          cnt_d = CW'(1);
        end
      end
      S_END: begin
        if (edge_det) cnt_d = CW'(1);
        else if (cnt_q == C_T2) begin
          frame_end_d = 1'b1;
          active_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output decode: status outputs and the debug view of the FSM state.
  always_comb begin
    active            = active_q;
    frame_end         = frame_end_q;
    error             = error_q;
    dbg_state         = state_q;
    data              = empty ? 10'd0 : mem_q[rd_ptr_q][9:0];
    data_parity_error = empty ? 1'b0 : mem_q[rd_ptr_q][10];
  end

  // FIFO occupancy count.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful under the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_word_q;
  end

endmodule
